// File: rtl/sic_dispatcher.sv
// Packet types shared by the dispatcher and the SIC array, and the
// dispatcher itself: an in-order packet queue that stamps issue ids and
// hands each packet to one requesting SIC as a one-cycle pulse.

package sic_dispatcher_pkg;

  localparam int unsigned ISSUE_ID_W = 8;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned OPC_W      = 8;
  localparam int unsigned TAG_W      = 6;

  // Renamed instruction packet as seen on a SIC packet_in port
  typedef struct packed {
    logic                  valid;
    logic [ISSUE_ID_W-1:0] issue_id;
    logic [PC_W-1:0]       pc;
    logic [OPC_W-1:0]      opcode;
    logic [TAG_W-1:0]      dst_tag;
  } sic_packet_t;

endpackage : sic_dispatcher_pkg

// ID_WIDTH must not exceed ISSUE_ID_W; the stamped id is zero-extended
// into the packet's issue_id field.
module sic_dispatcher
  import sic_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_SIC     = 4,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned ID_WIDTH    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  sic_packet_t                          in_packet,
  input  logic                                 flush,
  input  logic        [NUM_SIC-1:0]            sic_req_instr,
  output sic_packet_t [NUM_SIC-1:0]            sic_packet,
  output logic        [$clog2(QUEUE_DEPTH):0]  queue_count,
  output logic        [ID_WIDTH-1:0]           next_issue_id
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SIC_W = (NUM_SIC > 1) ? $clog2(NUM_SIC) : 1;

  // Architectural state
  logic [CNT_W-1:0]              count_q;
  logic [PTR_W-1:0]              rd_ptr_q;
  logic [PTR_W-1:0]              wr_ptr_q;
  logic [SIC_W-1:0]              rr_ptr_q;
  logic [ID_WIDTH-1:0]           id_q;
  sic_packet_t                   queue_q [QUEUE_DEPTH];
  sic_packet_t [NUM_SIC-1:0]     pkt_q;

  // Per-cycle decisions
  logic [NUM_SIC-1:0]            pulse_vec_c;
  logic [NUM_SIC-1:0]            eligible_c;
  logic                          win_found_c;
  logic [SIC_W-1:0]              win_idx_c;
  logic [SIC_W-1:0]              rr_next_c;
  logic                          push_c;
  logic                          pop_c;
  sic_packet_t                   wr_pkt_c;

  // Queue accepts whenever not full; based on the pre-flush occupancy
  assign in_ready = (count_q < CNT_W'(QUEUE_DEPTH));

  // A flush swallows a same-cycle push and blocks dispatch
  assign push_c = in_valid && in_ready && !flush;
  assign pop_c  = (count_q != '0) && win_found_c && !flush;

  // Gather the pulses currently on the SIC ports
  always_comb begin
    pulse_vec_c = '0;
    for (int unsigned i = 0; i < NUM_SIC; i++) begin
      pulse_vec_c[i] = pkt_q[i].valid;
    end
  end

  // A SIC holding a pulse this cycle is not eligible; this also keeps the
  // SIC's req path from looping back through packet_in combinationally
  assign eligible_c = sic_req_instr & ~pulse_vec_c;

  // Round-robin pick: first eligible SIC at or after rr_ptr
  always_comb begin : p_arb
    int unsigned idx;
    idx         = 0;
    win_found_c = 1'b0;
    win_idx_c   = '0;
    for (int unsigned k = 0; k < NUM_SIC; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_SIC;
      if (!win_found_c && eligible_c[SIC_W'(idx)]) begin
        win_found_c = 1'b1;
        win_idx_c   = SIC_W'(idx);
      end
    end
  end

  // Pointer that follows the winner, wrapping at NUM_SIC
  always_comb begin
    rr_next_c = '0;
    if (32'(win_idx_c) != NUM_SIC - 1) begin
      rr_next_c = win_idx_c + SIC_W'(1);
    end
  end

  // Incoming packet with its stamped id; front-end valid/id are overridden
  always_comb begin
    wr_pkt_c          = in_packet;
    wr_pkt_c.valid    = 1'b1;
    wr_pkt_c.issue_id = ISSUE_ID_W'(id_q);
  end

  // Queue occupancy and read/write pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (flush) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop_c && !push_c) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Packet storage, written at the tail on every accepted push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        queue_q[i] <= '0;
      end
    end else if (push_c) begin
      queue_q[wr_ptr_q] <= wr_pkt_c;
    end
  end

  // Issue id counter; survives flush, wraps at 2^ID_WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q <= '0;
    end else if (push_c) begin
      id_q <= id_q + ID_WIDTH'(1);
    end
  end

  // Round-robin pointer moves only when a dispatch happens
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (pop_c) begin
      rr_ptr_q <= rr_next_c;
    end
  end

  // SIC ports: every pulse self-clears after one cycle, payload holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SIC; i++) begin
        pkt_q[i].valid <= 1'b0;
      end
      if (pop_c) begin
        pkt_q[win_idx_c] <= queue_q[rd_ptr_q];
      end
    end
  end

  assign sic_packet    = pkt_q;
  assign queue_count   = count_q;
  assign next_issue_id = id_q;

endmodule : sic_dispatcher

// File: tb/tb_sic_dispatcher.sv
// Directed bench for sic_dispatcher: a default instance and an ID_WIDTH=3
// instance share all stimulus; the narrow one is only checked on id wrap.

module tb_sic_dispatcher;
  import sic_dispatcher_pkg::*;

  logic                       clk;
  logic                       rst_n;
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_ready3;
  sic_packet_t                in_packet;
  logic                       flush;
  logic        [3:0]          req;
  sic_packet_t [3:0]          pkt;
  sic_packet_t [3:0]          pkt3;
  logic        [2:0]          qcnt;
  logic        [2:0]          qcnt3;
  logic        [3:0]          nid;
  logic        [2:0]          nid3;
  logic        [3:0]          vv;
  logic        [3:0]          vv3;

  int n_checks = 0;
  int n_pass   = 0;

  sic_dispatcher #(.NUM_SIC(4), .QUEUE_DEPTH(4), .ID_WIDTH(4)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_packet     (in_packet),
    .flush         (flush),
    .sic_req_instr (req),
    .sic_packet    (pkt),
    .queue_count   (qcnt),
    .next_issue_id (nid)
  );

  sic_dispatcher #(.NUM_SIC(4), .QUEUE_DEPTH(4), .ID_WIDTH(3)) u_dut3 (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready3),
    .in_packet     (in_packet),
    .flush         (flush),
    .sic_req_instr (req),
    .sic_packet    (pkt3),
    .queue_count   (qcnt3),
    .next_issue_id (nid3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      vv[i]  = pkt[i].valid;
      vv3[i] = pkt3[i].valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    req      = 4'b0000;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Front-end packet; valid/issue_id deliberately junk, the DUT overrides them
  function automatic sic_packet_t mk(input logic [31:0] pc);
    sic_packet_t p;
    p.valid    = 1'b1;
    p.issue_id = 8'hFF;
    p.pc       = pc;
    p.opcode   = pc[9:2];
    p.dst_tag  = pc[7:2];
    return p;
  endfunction

  initial begin
    logic [3:0] exp_vv [6];
    logic [2:0] exp_cnt [6];
    exp_vv  = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    exp_cnt = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0};

    in_packet = '0;
    do_reset();

    // Idle after reset
    check("rst_valid", 32'(vv), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);
    check("rst_count", 32'(qcnt), 32'h0);
    check("rst_nid",   32'(nid), 32'h0);

    // Single packet to SIC0: queued at edge 1, pulsed after edge 2
    req       = 4'b0001;
    in_packet = mk(32'h0040_0000);
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    check("one_cnt_q",   32'(qcnt), 32'h1);
    check("one_nopulse", 32'(vv), 32'h0);
    check("one_nid",     32'(nid), 32'h1);
    tick();
    check("one_pulse", 32'(vv), 32'h1);
    check("one_id",    32'(pkt[0].issue_id), 32'h0);
    check("one_pc",    pkt[0].pc, 32'h0040_0000);
    check("one_cnt_d", 32'(qcnt), 32'h0);
    req = 4'b0000;
    tick();
    check("one_clear", 32'(vv), 32'h0);
    check("one_hold",  pkt[0].pc, 32'h0040_0000);

    // Four back-to-back pushes, all SICs requesting: round-robin 0,1,2,3
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      in_valid  = (i < 4);
      in_packet = mk(32'h1000 + 32'(4 * i));
      tick();
      check($sformatf("rr_vv%0d", i),  32'(vv), 32'(exp_vv[i]));
      check($sformatf("rr_cnt%0d", i), 32'(qcnt), 32'(exp_cnt[i]));
      if (i >= 1 && i <= 4) begin
        check($sformatf("rr_id%0d", i), 32'(pkt[i-1].issue_id), 32'(i - 1));
        check($sformatf("rr_pc%0d", i), pkt[i-1].pc, 32'h1000 + 32'(4 * (i - 1)));
      end
    end
    req = 4'b0000;

    // Fill to full with nobody requesting, then SIC2 drains one
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_packet = mk(32'h2000 + 32'(4 * i));
      tick();
      check($sformatf("fill_cnt%0d", i), 32'(qcnt), 32'(i + 1));
    end
    in_packet = mk(32'h2010);
    check("full_ready0", 32'(in_ready), 32'h0);
    tick();
    check("full_cnt", 32'(qcnt), 32'h4);
    check("full_nid", 32'(nid), 32'h4);
    req = 4'b0100;
    tick();
    check("full_pop_vv", 32'(vv), 32'h4);
    check("full_pop_id", 32'(pkt[2].issue_id), 32'h0);
    check("full_pop_cnt", 32'(qcnt), 32'h3);
    check("full_ready1", 32'(in_ready), 32'h1);
    req = 4'b0000;
    tick();
    in_valid = 1'b0;
    check("fifth_cnt", 32'(qcnt), 32'h4);
    check("fifth_nid", 32'(nid), 32'h5);
    req = 4'b1111;
    tick();
    check("drain_s3", 32'(vv), 32'h8);
    check("drain_id1", 32'(pkt[3].issue_id), 32'h1);
    tick();
    check("drain_s0", 32'(vv), 32'h1);
    check("drain_id2", 32'(pkt[0].issue_id), 32'h2);
    tick();
    check("drain_s1", 32'(vv), 32'h2);
    check("drain_id3", 32'(pkt[1].issue_id), 32'h3);
    tick();
    check("drain_s2", 32'(vv), 32'h4);
    check("drain_id4", 32'(pkt[2].issue_id), 32'h4);
    check("drain_pc4", pkt[2].pc, 32'h2010);
    req = 4'b0000;

    // Flush with a queued backlog and a same-cycle push
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_packet = mk(32'h3000 + 32'(4 * i));
      tick();
    end
    check("fl_pre_cnt", 32'(qcnt), 32'h3);
    in_packet = mk(32'h3100);
    flush     = 1'b1;
    req       = 4'b1111;
    check("fl_ready", 32'(in_ready), 32'h1);
    tick();
    flush = 1'b0;
    check("fl_cnt", 32'(qcnt), 32'h0);
    check("fl_nodisp", 32'(vv), 32'h0);
    check("fl_nid", 32'(nid), 32'h3);
    in_packet = mk(32'h3200);
    tick();
    in_valid = 1'b0;
    check("fl_push_cnt", 32'(qcnt), 32'h1);
    tick();
    check("fl_disp_vv", 32'(vv), 32'h1);
    check("fl_disp_id", 32'(pkt[0].issue_id), 32'h3);
    check("fl_disp_pc", pkt[0].pc, 32'h3200);
    req = 4'b0000;

    // Narrow-id instance: ten streamed packets wrap ids 0..7,0,1
    do_reset();
    req      = 4'b1111;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_packet = mk(32'h4000 + 32'(4 * i));
      tick();
      check($sformatf("w3_nid%0d", i), 32'(nid3), 32'((i + 1) % 8));
      if (i >= 1) begin
        check($sformatf("w3_vv%0d", i), 32'(vv3), 32'(1 << ((i - 1) % 4)));
        check($sformatf("w3_id%0d", i), 32'(pkt3[(i - 1) % 4].issue_id), 32'((i - 1) % 8));
      end
    end
    check("w3_pre_rst_cnt", 32'(qcnt3), 32'h1);

    // Asynchronous reset mid-stream clears everything before the next edge
    #2 rst_n = 1'b0;
    #1;
    check("arst_vv3",  32'(vv3), 32'h0);
    check("arst_nid3", 32'(nid3), 32'h0);
    check("arst_cnt3", 32'(qcnt3), 32'h0);
    check("arst_vv",   32'(vv), 32'h0);
    check("arst_nid",  32'(nid), 32'h0);
    check("arst_cnt",  32'(qcnt), 32'h0);
    check("arst_pkt",  32'(pkt3[1].pc), 32'h0);
    in_valid = 1'b0;
    req      = 4'b0000;
    #5 rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sic_dispatcher
